arith_result_acc: RTL and testbench

Sequential result stage directly downstream of the 2-bit arithmetic unit. It accepts one arithmetic result per transaction through a valid/ready handshake, and selects either the sum or the product. The selected 4-bit result is held as the last result and added into a running accumulator. The block reports completion with a one-cycle pulse and feeds the lab display/LED logic.

---
 rtl/arith_pkg.sv | 15 +
 rtl/acc_adder_sat.sv | 23 ++
 rtl/arith_result_acc.sv | 93 +++++++++
 tb/tb_arith_result_acc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic result stage.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } acc_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int ACC_W_DEF = 8;

endpackage

// File: rtl/acc_adder_sat.sv
// Accumulator adder with carry-out; optional clamp to all-ones when ACC_SATURATE_EN is defined.
module acc_adder_sat #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       operand,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] wide;

  assign wide  = {1'b0, acc} + {{(ACC_W-3){1'b0}}, operand};
  assign carry = wide[ACC_W];

`ifdef ACC_SATURATE_EN
  // Once at all-ones, any non-zero operand carries again, so the clamp holds.
  assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/arith_result_acc.sv
// Result stage: selects sum/product per handshake and accumulates it over three cycles.
// Build option: ACC_SATURATE_EN clamps the accumulator instead of wrapping.
module arith_result_acc
  import arith_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sel,
  input  logic [3:0]       add,
  input  logic [3:0]       multiply,
  input  logic             clear,
  output logic [3:0]       last_out,
  output logic [ACC_W-1:0] acc_out,
  output logic [3:0]       count,
  output logic             out_valid,
  output logic             overflow
);

  acc_state_t       state_reg;
  logic [3:0]       last_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [3:0]       count_reg;
  logic             out_valid_reg;
  logic             overflow_reg;

  logic [ACC_W-1:0] sum_next;
  logic             carry_next;

  acc_adder_sat #(
    .ACC_W(ACC_W)
  ) u_adder (
    .acc    (acc_reg),
    .operand(last_reg),
    .sum    (sum_next),
    .carry  (carry_next)
  );

  assign in_ready = (state_reg == IDLE) && !clear && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_reg      <= 4'd0;
      acc_reg       <= '0;
      count_reg     <= 4'd0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (clear) begin
      // last result is deliberately kept across a clear
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= 4'd0;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          out_valid_reg <= 1'b0;
          if (in_valid && in_ready) begin
            last_reg  <= (op_sel == OP_MUL) ? multiply : add;
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          acc_reg       <= sum_next;
          count_reg     <= count_reg + 4'd1;
          overflow_reg  <= overflow_reg | carry_next;
          out_valid_reg <= 1'b1;
          state_reg     <= REPORT;
        end
        REPORT: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign last_out  = last_reg;
  assign acc_out   = acc_reg;
  assign count     = count_reg;
  assign out_valid = out_valid_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_arith_result_acc.sv
// Scoreboard bench for arith_result_acc at ACC_W=5 (wrap or saturate per ACC_SATURATE_EN).
module tb_arith_result_acc;

  localparam int TB_W = 5;
  localparam int TB_MAX = (1 << TB_W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            op_sel;
  logic [3:0]      add;
  logic [3:0]      multiply;
  logic            clear;
  logic [3:0]      last_out;
  logic [TB_W-1:0] acc_out;
  logic [3:0]      count;
  logic            out_valid;
  logic            overflow;

  typedef struct {
    int last;
    int acc;
    int cnt;
    int ovf;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_bad = 0;

  int model_last = 0;
  int model_acc  = 0;
  int model_cnt  = 0;
  int model_ovf  = 0;

  arith_result_acc #(
    .ACC_W(TB_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sel   (op_sel),
    .add      (add),
    .multiply (multiply),
    .clear    (clear),
    .last_out (last_out),
    .acc_out  (acc_out),
    .count    (count),
    .out_valid(out_valid),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every out_valid pulse must match the oldest accepted transaction.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("sb_acc", 32'(acc_out), e.acc);
        check_val("sb_count", 32'(count), e.cnt);
        check_val("sb_overflow", 32'(overflow), e.ovf);
        check_val("sb_last", 32'(last_out), e.last);
        $display("txn: last=%0d acc=%0d count=%0d ovf=%0d", last_out, acc_out, count, overflow);
      end
    end
  end

  task automatic do_txn(input logic op, input logic [3:0] a, input logic [3:0] m, input bit hold);
    int t;
    int sel;
    int sum;
    exp_t e;
    in_valid = 1'b1;
    op_sel   = op;
    add      = a;
    multiply = m;
    t = 0;
    while (!in_ready && t < 10) begin
      step();
      t++;
    end
    if (!in_ready) begin
      check_val("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    sel = op ? int'(m) : int'(a);
    sum = model_acc + sel;
    model_last = sel;
    if (sum > TB_MAX) begin
      model_ovf = 1;
`ifdef ACC_SATURATE_EN
      model_acc = TB_MAX;
`else
      model_acc = sum - (TB_MAX + 1);
`endif
    end else begin
      model_acc = sum;
    end
    model_cnt = (model_cnt + 1) % 16;
    e.last = model_last;
    e.acc  = model_acc;
    e.cnt  = model_cnt;
    e.ovf  = model_ovf;
    sb_q.push_back(e);
    step();  // cycle N+1 (ACCUM)
    if (!hold) in_valid = 1'b0;
    check_val("accum_ready", 32'(in_ready), 0);
    check_val("accum_out_valid", 32'(out_valid), 0);
    check_val("accum_last", 32'(last_out), model_last);
    step();  // cycle N+2 (REPORT)
    check_val("report_out_valid", 32'(out_valid), 1);
    check_val("report_ready", 32'(in_ready), 0);
    step();  // cycle N+3
    in_valid = 1'b0;
    check_val("post_out_valid", 32'(out_valid), 0);
    check_val("post_ready", 32'(in_ready), 1);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    op_sel   = 1'b0;
    add      = 4'd0;
    multiply = 4'd0;
    clear    = 1'b0;

    step();
    step();
    check_val("rst_ready", 32'(in_ready), 0);
    check_val("rst_last", 32'(last_out), 0);
    check_val("rst_acc", 32'(acc_out), 0);
    check_val("rst_count", 32'(count), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    #1;
    check_val("idle_ready", 32'(in_ready), 1);
    step();
    check_val("idle_out_valid", 32'(out_valid), 0);

    // Single multiply, then continue to overflow at 5 bits.
    do_txn(1'b1, 4'd6, 4'd9, 1'b0);
    for (int i = 0; i < 3; i++) do_txn(1'b1, 4'd0, 4'd9, 1'b0);
    check_val("ovf_sticky", 32'(overflow), 1);
    do_txn(1'b0, 4'd1, 4'd0, 1'b0);

    // Clear during the ACCUM cycle discards that accumulation.
    in_valid = 1'b1;
    op_sel   = 1'b0;
    add      = 4'd5;
    multiply = 4'd2;
    check_val("clr_pre_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    clear    = 1'b1;
    #1;
    check_val("clr_accum_ready", 32'(in_ready), 0);
    step();
    clear = 1'b0;
    #1;
    model_last = 5; model_acc = 0; model_cnt = 0; model_ovf = 0;
    check_val("clr_acc", 32'(acc_out), 0);
    check_val("clr_count", 32'(count), 0);
    check_val("clr_overflow", 32'(overflow), 0);
    check_val("clr_out_valid", 32'(out_valid), 0);
    check_val("clr_last", 32'(last_out), 5);
    check_val("clr_idle_ready", 32'(in_ready), 1);
    step();
    check_val("clr_no_pulse", 32'(out_valid), 0);

    // Mixed sequence, one with in_valid held through busy cycles.
    do_txn(1'b0, 4'd3, 4'd1, 1'b0);
    do_txn(1'b1, 4'd2, 4'd4, 1'b1);
    do_txn(1'b0, 4'd6, 4'd9, 1'b0);
    check_val("mixed_acc", 32'(acc_out), 13);

    // Clear in IDLE blocks a simultaneous offer.
    in_valid = 1'b1;
    op_sel   = 1'b0;
    add      = 4'd7;
    clear    = 1'b1;
    #1;
    check_val("clr_idle_ready", 32'(in_ready), 0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    model_acc = 0; model_cnt = 0; model_ovf = 0;
    check_val("clr_idle_last", 32'(last_out), 6);
    check_val("clr_idle_acc", 32'(acc_out), 0);
    step();
    step();
    check_val("clr_idle_count", 32'(count), 0);
    check_val("clr_idle_out_valid", 32'(out_valid), 0);

    // count wraps after 16 accumulations.
    for (int i = 0; i < 16; i++) do_txn(1'b0, 4'd1, 4'd0, 1'b0);
    check_val("wrap_count", 32'(count), 0);
    check_val("wrap_acc", 32'(acc_out), 16);
    check_val("wrap_overflow", 32'(overflow), 0);

    step();
    check_val("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
